// File: rtl/eco_patch_lut_if.sv
// Config and evaluation bundle for eco_patch_lut: serial table load handshake
// plus the registered evaluation path. master drives requests, slave answers.
interface eco_patch_lut_if #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 1
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_bit;
  logic               cfg_last;
  logic               cfg_err;
  logic               in_valid;
  logic [NUM_IN-1:0]  in_vec;
  logic [NUM_OUT-1:0] orig_vec;
  logic               out_valid;
  logic [NUM_OUT-1:0] out_vec;
  logic               patch_active;

  modport master (
    output cfg_valid, cfg_bit, cfg_last, in_valid, in_vec, orig_vec,
    input  cfg_ready, cfg_err, out_valid, out_vec, patch_active
  );

  modport slave (
    input  cfg_valid, cfg_bit, cfg_last, in_valid, in_vec, orig_vec,
    output cfg_ready, cfg_err, out_valid, out_vec, patch_active
  );
endinterface

// File: rtl/eco_patch_lut.sv
// Runtime-programmable LUT patch cell: bypasses orig_vec until a serially loaded
// table commits. Define PATCH_CFG_PARITY_EN to require an even-parity bit after the table.
module eco_patch_lut #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 1
) (
  input  logic clk,
  input  logic rst,
  eco_patch_lut_if.slave bus
);
  localparam int MINTERMS = 2 ** NUM_IN;
  localparam int TBL_BITS = NUM_OUT * MINTERMS;
  localparam int IDX_W    = (TBL_BITS > 1) ? $clog2(TBL_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef PATCH_CFG_PARITY_EN
    PARITY,
`endif
    COMMIT
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     count_reg, count_next;
  logic [TBL_BITS-1:0]  shadow_reg;
  logic [TBL_BITS-1:0]  active_reg;
  logic                 patch_active_reg;
  logic                 err_reg, err_next;
  logic                 shadow_we;
  logic                 shadow_clr;
  logic                 final_bit;
  logic                 out_valid_reg;
  logic [NUM_OUT-1:0]   out_vec_reg;
  logic [NUM_OUT-1:0]   lut_vec;

  // count_reg is always 0 in IDLE, so IDLE and LOAD share the same bit handling
  assign final_bit = (count_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = 1'b0;
    shadow_we  = 1'b0;
    shadow_clr = 1'b0;
    case (state_reg)
      IDLE, LOAD: begin
        if (bus.cfg_valid) begin
          shadow_we = 1'b1;
          if (bus.cfg_last && final_bit) begin
`ifdef PATCH_CFG_PARITY_EN
            state_next = PARITY;
`else
            state_next = COMMIT;
`endif
            count_next = '0;
          end else if (bus.cfg_last || final_bit) begin
            err_next   = 1'b1;
            shadow_clr = 1'b1;
            state_next = IDLE;
            count_next = '0;
          end else begin
            state_next = LOAD;
            count_next = count_reg + IDX_W'(1);
          end
        end
      end
`ifdef PATCH_CFG_PARITY_EN
      PARITY: begin
        if (bus.cfg_valid) begin
          if (bus.cfg_bit == ^shadow_reg) begin
            state_next = COMMIT;
          end else begin
            err_next   = 1'b1;
            shadow_clr = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      err_reg          <= 1'b0;
      shadow_reg       <= '0;
      active_reg       <= '0;
      patch_active_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      if (shadow_clr) begin
        shadow_reg <= '0;
      end else if (shadow_we) begin
        shadow_reg[count_reg] <= bus.cfg_bit;
      end
      if (state_reg == COMMIT) begin
        active_reg       <= shadow_reg;
        patch_active_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_lut
      logic [MINTERMS-1:0] row;
      assign row         = active_reg[gi*MINTERMS +: MINTERMS];
      assign lut_vec[gi] = row[bus.in_vec];
    end
  endgenerate

  // Evaluation reads the active table as it stood before this edge, so a
  // request in the COMMIT cycle still sees the old table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_vec_reg   <= '0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        out_vec_reg <= patch_active_reg ? lut_vec : bus.orig_vec;
      end
    end
  end

  assign bus.cfg_ready    = (state_reg != COMMIT);
  assign bus.cfg_err      = err_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_vec      = out_vec_reg;
  assign bus.patch_active = patch_active_reg;
endmodule

// File: tb/tb_eco_patch_lut.sv
// Scoreboard bench for eco_patch_lut: a queue-based load model predicts each
// response; a negedge monitor pops and compares whenever out_valid is seen.
module tb_eco_patch_lut;
  localparam int NUM_IN   = 4;
  localparam int NUM_OUT  = 1;
  localparam int MINTERMS = 2 ** NUM_IN;
  localparam int TBL      = NUM_OUT * MINTERMS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eco_patch_lut_if #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

  eco_patch_lut #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model: accepted bits collected in a queue, judged on length
  bit [TBL-1:0]       m_tbl;
  bit                 m_active;
  bit                 m_pend;
  bit                 m_par;
  bit                 m_err;
  bit                 m_shadow[$];
  logic [NUM_OUT-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit shadow_xor();
    bit x = 1'b0;
    foreach (m_shadow[i]) x ^= m_shadow[i];
    return x;
  endfunction

  task automatic model_edge(input logic cv, input logic cb, input logic cl,
                            input logic iv, input logic [NUM_IN-1:0] vec,
                            input logic [NUM_OUT-1:0] orig);
    logic [NUM_OUT-1:0] e;
    if (iv) begin
      for (int o = 0; o < NUM_OUT; o++)
        e[o] = m_active ? m_tbl[o*MINTERMS + int'(vec)] : orig[o];
      exp_q.push_back(e);
    end
    m_err = 1'b0;
    if (m_pend) begin
      for (int k = 0; k < TBL; k++) m_tbl[k] = m_shadow[k];
      m_active = 1'b1;
      m_pend   = 1'b0;
      m_shadow.delete();
    end else if (cv) begin
      if (m_par) begin
        m_par = 1'b0;
        if (cb == shadow_xor()) m_pend = 1'b1;
        else begin m_err = 1'b1; m_shadow.delete(); end
      end else begin
        m_shadow.push_back(cb);
        if (cl && m_shadow.size() == TBL) begin
`ifdef PATCH_CFG_PARITY_EN
          m_par = 1'b1;
`else
          m_pend = 1'b1;
`endif
        end else if (cl || m_shadow.size() == TBL) begin
          m_err = 1'b1;
          m_shadow.delete();
        end
      end
    end
  endtask

  task automatic step(input logic cv, input logic cb, input logic cl,
                      input logic iv, input logic [NUM_IN-1:0] vec,
                      input logic [NUM_OUT-1:0] orig);
    bus.cfg_valid = cv;
    bus.cfg_bit   = cb;
    bus.cfg_last  = cl;
    bus.in_valid  = iv;
    bus.in_vec    = vec;
    bus.orig_vec  = orig;
    @(posedge clk);
    model_edge(cv, cb, cl, iv, vec, orig);
    @(negedge clk);
    $display("step cv=%0b bit=%0b last=%0b iv=%0b vec=%0h ready=%0b err=%0b active=%0b",
             cv, cb, cl, iv, vec, bus.cfg_ready, bus.cfg_err, bus.patch_active);
    check("cfg_ready", 32'(bus.cfg_ready), 32'(!m_pend));
    check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    check("patch_active", 32'(bus.patch_active), 32'(m_active));
    check("out_valid", 32'(bus.out_valid), 32'(iv));
  endtask

  task automatic rand_step(input logic cv, input logic cb, input logic cl, input bit fixed_f);
    if (fixed_f) step(cv, cb, cl, 1'b1, '1, '0);
    else step(cv, cb, cl, 1'($urandom_range(0, 1)), NUM_IN'($urandom), NUM_OUT'($urandom));
  endtask

  // streams nbits with cfg_last at last_idx (-1: never), then idles over any commit
  task automatic load(input logic [TBL-1:0] tbl, input int nbits, input int last_idx,
                      input bit par_flip, input bit fixed_f, input bit gaps);
    int i = 0;
    while (i < nbits) begin
      if (gaps && $urandom_range(0, 3) == 0) rand_step(1'b0, 1'b0, 1'b0, fixed_f);
      else begin
        rand_step(1'b1, tbl[i], 1'(i == last_idx), fixed_f);
        i++;
      end
    end
`ifdef PATCH_CFG_PARITY_EN
    if (nbits == TBL && last_idx == TBL - 1)
      rand_step(1'b1, (^tbl) ^ par_flip, 1'($urandom_range(0, 1)), fixed_f);
`else
    if (par_flip && nbits < 0) rand_step(1'b0, 1'b0, 1'b0, fixed_f);
`endif
    rand_step(1'b0, 1'b0, 1'b0, fixed_f);
    rand_step(1'b0, 1'b0, 1'b0, fixed_f);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    m_tbl = '0; m_active = 0; m_pend = 0; m_par = 0; m_err = 0;
    m_shadow.delete();
    exp_q.delete();
    #2;
    $display("reset applied");
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_vec", 32'(bus.out_vec), 32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("rst_patch_active", 32'(bus.patch_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL out_vec: got %0h with no request outstanding", bus.out_vec);
      end else begin
        logic [NUM_OUT-1:0] e;
        e = exp_q.pop_front();
        $display("result out_vec=%0h expected=%0h", bus.out_vec, e);
        check("out_vec", 32'(bus.out_vec), 32'(e));
      end
    end
  end

  initial begin
    logic [TBL-1:0] t;
    bus.cfg_valid = 0; bus.cfg_bit = 0; bus.cfg_last = 0;
    bus.in_valid = 0; bus.in_vec = '0; bus.orig_vec = '0;
    rst = 1'b1;
    do_reset();

    // bypass before any commit
    step(1'b0, 1'b0, 1'b0, 1'b1, '1, 1'b1);

    // AND4 table
    t = 16'h8000;
    load(t, TBL, TBL - 1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, NUM_IN'(14), 1'b1);

    // early last on bit 9
    t = 16'h5A5A;
    load(t, 10, 9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '1, 1'b1);

    // load while evaluating every cycle
    t = 16'h0001;
    load(t, TBL, TBL - 1, 1'b0, 1'b1, 1'b0);

    // missing last on final bit
    t = 16'hFFFF;
    load(t, TBL, -1, 1'b0, 1'b0, 1'b0);

`ifdef PATCH_CFG_PARITY_EN
    t = 16'h8000;
    load(t, TBL, TBL - 1, 1'b1, 1'b0, 1'b0);
    load(t, TBL, TBL - 1, 1'b0, 1'b0, 1'b0);
`endif

    // reset mid-load, then a clean load
    t = 16'hC3A5;
    for (int i = 0; i < 8; i++) rand_step(1'b1, t[i], 1'b0, 1'b0);
    do_reset();
    load(t, TBL, TBL - 1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, NUM_IN'(0), 1'b1);

    // randomized loads of all kinds with valid gaps and random evaluation
    for (int n = 0; n < 40; n++) begin
      int kind;
      int nb;
      int li;
      t = TBL'($urandom);
      kind = $urandom_range(0, 3);
      if (kind < 2) begin
        nb = TBL; li = TBL - 1;
      end else begin
        nb = $urandom_range(1, TBL + 3);
        li = ($urandom_range(0, 1) != 0) ? $urandom_range(0, nb - 1) : -1;
      end
      load(t, nb, li, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      for (int j = 0; j < 4; j++) rand_step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
